// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter feeding a one-deep issue stage in front of a shared
// 4-bit ALU, with one held response slot per requester. Optional: ALU_ARB_OVF_STICKY_EN.
module alu_arbiter #(
  parameter int PRIO_INIT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [2:0] req0_op,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [2:0] req1_op,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  output logic       rsp0_valid,
  input  logic       rsp0_ready,
  output logic [3:0] rsp0_result,
  output logic       rsp0_overflow,
  output logic       rsp0_zero,
  output logic       rsp1_valid,
  input  logic       rsp1_ready,
  output logic [3:0] rsp1_result,
  output logic       rsp1_overflow,
  output logic       rsp1_zero,
  output logic [2:0] alu_op,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  input  logic [3:0] alu_result,
  input  logic       alu_overflow,
  input  logic       alu_zero,
  output logic       busy
`ifdef ALU_ARB_OVF_STICKY_EN
  ,
  output logic       ovf_sticky0,
  output logic       ovf_sticky1,
  input  logic       ovf_clr
`endif
);

  logic [1:0] w_req_valid;
  logic [1:0] w_rsp_ready;
  logic [2:0] w_req_op [2];
  logic [3:0] w_req_a  [2];
  logic [3:0] w_req_b  [2];

  assign w_req_valid = {req1_valid, req0_valid};
  assign w_rsp_ready = {rsp1_ready, rsp0_ready};
  assign w_req_op[0] = req0_op;
  assign w_req_op[1] = req1_op;
  assign w_req_a[0]  = req0_a;
  assign w_req_a[1]  = req1_a;
  assign w_req_b[0]  = req0_b;
  assign w_req_b[1]  = req1_b;

  logic       r_iss_valid;
  logic       r_iss_owner;
  logic [2:0] r_iss_op;
  logic [3:0] r_iss_a;
  logic [3:0] r_iss_b;
  logic       r_last;

  logic [1:0] w_inflight;
  logic [1:0] w_elig;
  logic [1:0] w_full;
  logic [3:0] w_res [2];
  logic [1:0] w_ovf;
  logic [1:0] w_zero;
  logic       w_grant_any;
  logic       w_grant_id;

  // The issue stage always drains in one cycle, so the slot capture is simply "inflight".
  // A slot is guaranteed empty at capture because the grant required it empty or draining.
  for (genvar gi = 0; gi < 2; gi++) begin : g_slot
    logic       r_full;
    logic [3:0] r_res;
    logic       r_ovf;
    logic       r_zero;

    assign w_inflight[gi] = r_iss_valid && (r_iss_owner == 1'(gi));
    assign w_elig[gi]     = w_req_valid[gi] && !w_inflight[gi]
                            && (!r_full || w_rsp_ready[gi]);

    always_ff @(posedge clk) begin
      if (rst) begin
        r_full <= 1'b0;
        r_res  <= 4'd0;
        r_ovf  <= 1'b0;
        r_zero <= 1'b0;
      end else if (w_inflight[gi]) begin
        r_full <= 1'b1;
        r_res  <= alu_result;
        r_ovf  <= alu_overflow;
        r_zero <= alu_zero;
      end else if (r_full && w_rsp_ready[gi]) begin
        r_full <= 1'b0;
      end
    end

    assign w_full[gi] = r_full;
    assign w_res[gi]  = r_res;
    assign w_ovf[gi]  = r_ovf;
    assign w_zero[gi] = r_zero;
  end

  always_comb begin
    w_grant_any = (|w_elig) && !rst;
    w_grant_id  = (&w_elig) ? ~r_last : w_elig[1];
  end

  assign req0_ready = w_grant_any && !w_grant_id;
  assign req1_ready = w_grant_any && w_grant_id;

  // r_last holds the most recent winner; resetting it to the other requester hands the
  // first tie to PRIO_INIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_iss_valid <= 1'b0;
      r_iss_owner <= 1'b0;
      r_iss_op    <= 3'd0;
      r_iss_a     <= 4'd0;
      r_iss_b     <= 4'd0;
      r_last      <= (PRIO_INIT == 0);
    end else begin
      r_iss_valid <= w_grant_any;
      if (w_grant_any) begin
        r_iss_owner <= w_grant_id;
        r_iss_op    <= w_req_op[w_grant_id];
        r_iss_a     <= w_req_a[w_grant_id];
        r_iss_b     <= w_req_b[w_grant_id];
        r_last      <= w_grant_id;
      end
    end
  end

  assign alu_op = r_iss_valid ? r_iss_op : 3'd0;
  assign alu_a  = r_iss_valid ? r_iss_a  : 4'd0;
  assign alu_b  = r_iss_valid ? r_iss_b  : 4'd0;

  assign rsp0_valid    = w_full[0];
  assign rsp0_result   = w_res[0];
  assign rsp0_overflow = w_ovf[0];
  assign rsp0_zero     = w_zero[0];
  assign rsp1_valid    = w_full[1];
  assign rsp1_result   = w_res[1];
  assign rsp1_overflow = w_ovf[1];
  assign rsp1_zero     = w_zero[1];

  assign busy = r_iss_valid || (|w_full);

`ifdef ALU_ARB_OVF_STICKY_EN
  logic [1:0] r_sticky;

  // A capture with overflow sets its flag even on a clearing edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sticky <= 2'b00;
    end else begin
      r_sticky <= (ovf_clr ? 2'b00 : r_sticky) | (w_inflight & {2{alu_overflow}});
    end
  end

  assign ovf_sticky0 = r_sticky[0];
  assign ovf_sticky1 = r_sticky[1];
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a transaction-level reference checked every cycle,
// plus hand-computed literal expectations for the documented scenarios.
module tb_alu_arbiter;
  localparam int PRIO = 0;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic       req0_ready, req1_ready;
  logic [2:0] req0_op, req1_op;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic       rsp0_valid, rsp1_valid;
  logic       rsp0_ready, rsp1_ready;
  logic [3:0] rsp0_result, rsp1_result;
  logic       rsp0_overflow, rsp1_overflow, rsp0_zero, rsp1_zero;
  logic [2:0] alu_op;
  logic [3:0] alu_a, alu_b, alu_result;
  logic       alu_overflow, alu_zero;
  logic       busy;
`ifdef ALU_ARB_OVF_STICKY_EN
  logic       ovf_sticky0, ovf_sticky1;
  logic       ovf_clr;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.PRIO_INIT(PRIO)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
    .rsp0_overflow(rsp0_overflow), .rsp0_zero(rsp0_zero),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
    .rsp1_overflow(rsp1_overflow), .rsp1_zero(rsp1_zero),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_overflow(alu_overflow), .alu_zero(alu_zero),
    .busy(busy)
`ifdef ALU_ARB_OVF_STICKY_EN
    , .ovf_sticky0(ovf_sticky0), .ovf_sticky1(ovf_sticky1), .ovf_clr(ovf_clr)
`endif
  );

  // Reference ALU, returns {zero, overflow, result}.
  function automatic logic [5:0] alu_f(input logic [2:0] op, input logic [3:0] a,
                                       input logic [3:0] b);
    int sa, sb, r;
    logic ovf;
    logic [3:0] res;
    sa = int'($signed(a));
    sb = int'($signed(b));
    ovf = 1'b0;
    res = 4'd0;
    r = 0;
    case (op)
      3'd0, 3'd1: begin
        r = (op == 3'd0) ? sa + sb : sa - sb;
        if (r > 7 || r < -8) ovf = 1'b1;
        else res = 4'(r);
      end
      3'd2: res = ~a;
      3'd3: res = a & b;
      3'd4: res = a | b;
      3'd5: res = a ^ b;
      3'd6: res = (sa < sb) ? 4'd1 : 4'd0;
      default: res = 4'd0;
    endcase
    return {res == 4'd0, ovf, res};
  endfunction

  assign {alu_zero, alu_overflow, alu_result} = alu_f(alu_op, alu_a, alu_b);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Reference state: one pending transaction in issue, one held result per requester.
  logic       m_init = 1'b0;
  logic       m_iv, m_io, m_last;
  logic [2:0] m_iop;
  logic [3:0] m_ia, m_ib;
  logic [1:0] m_full;
  logic [5:0] m_slot [2];
  logic [1:0] m_sticky;

  always @(negedge clk) begin
    logic [1:0] rv, rr, infl, elig, gnt;
    logic gid;
    logic [5:0] cap;
    rv = {req1_valid, req0_valid};
    rr = {rsp1_ready, rsp0_ready};
    gid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      infl[i] = m_init && m_iv && (m_io == 1'(i));
      elig[i] = rv[i] && !infl[i] && (!m_full[i] || rr[i]);
    end
    gnt = 2'b00;
    if (!rst && elig != 2'b00) begin
      gid = (elig == 2'b11) ? !m_last : elig[1];
      gnt[gid] = 1'b1;
    end
    if (m_init) begin
      chk("ready", {30'd0, req1_ready, req0_ready}, {30'd0, gnt});
      chk("rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, {30'd0, m_full});
      chk("busy", {31'd0, busy}, {31'd0, m_iv || (m_full != 2'b00)});
      chk("alu_in", {21'd0, alu_op, alu_a, alu_b},
          m_iv ? {21'd0, m_iop, m_ia, m_ib} : 32'd0);
      if (m_full[0]) chk("rsp0_fields", {26'd0, rsp0_zero, rsp0_overflow, rsp0_result},
                         {26'd0, m_slot[0]});
      if (m_full[1]) chk("rsp1_fields", {26'd0, rsp1_zero, rsp1_overflow, rsp1_result},
                         {26'd0, m_slot[1]});
`ifdef ALU_ARB_OVF_STICKY_EN
      chk("sticky", {30'd0, ovf_sticky1, ovf_sticky0}, {30'd0, m_sticky});
`endif
    end
    if (rst) begin
      m_init = 1'b1;
      m_iv = 1'b0; m_io = 1'b0; m_iop = 3'd0; m_ia = 4'd0; m_ib = 4'd0;
      m_full = 2'b00; m_sticky = 2'b00;
      m_slot[0] = 6'd0; m_slot[1] = 6'd0;
      m_last = (PRIO == 0);
    end else if (m_init) begin
      cap = alu_f(m_iop, m_ia, m_ib);
`ifdef ALU_ARB_OVF_STICKY_EN
      if (ovf_clr) m_sticky = 2'b00;
`endif
      for (int i = 0; i < 2; i++) begin
        if (infl[i]) begin
          m_full[i] = 1'b1;
          m_slot[i] = cap;
          if (cap[4]) m_sticky[i] = 1'b1;
        end else if (m_full[i] && rr[i]) begin
          m_full[i] = 1'b0;
        end
      end
      m_iv = (gnt != 2'b00);
      if (gnt != 2'b00) begin
        m_io = gid;
        m_iop = gid ? req1_op : req0_op;
        m_ia = gid ? req1_a : req0_a;
        m_ib = gid ? req1_b : req0_b;
        m_last = gid;
      end
    end
  end

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit id, input bit v, input logic [2:0] op,
                         input logic [3:0] a, input logic [3:0] b);
    if (id) begin
      req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
    end else begin
      req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
    end
  endtask

  // Issue one request, then check {valid, zero, overflow, result} at grant+2.
  task automatic op_test(input string nm, input bit id, input logic [2:0] op,
                         input logic [3:0] a, input logic [3:0] b, input logic [5:0] exp);
    set_req(id, 1'b1, op, a, b);
    @(negedge clk);
    chk({nm, "_ready"}, {31'd0, id ? req1_ready : req0_ready}, 32'd1);
    cyc;
    set_req(id, 1'b0, 3'd0, 4'd0, 4'd0);
    cyc;
    @(negedge clk);
    if (id) chk(nm, {25'd0, rsp1_valid, rsp1_zero, rsp1_overflow, rsp1_result},
                {25'd0, 1'b1, exp});
    else    chk(nm, {25'd0, rsp0_valid, rsp0_zero, rsp0_overflow, rsp0_result},
                {25'd0, 1'b1, exp});
    $display("op_test %s id=%0d op=%0d a=%0h b=%0h", nm, id, op, a, b);
    cyc;
  endtask

  initial begin
    rst = 1'b1;
    set_req(1'b0, 1'b0, 3'd0, 4'd0, 4'd0);
    set_req(1'b1, 1'b0, 3'd0, 4'd0, 4'd0);
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
`ifdef ALU_ARB_OVF_STICKY_EN
    ovf_clr = 1'b0;
`endif
    cyc;
    cyc;
    @(negedge clk);
    chk("reset_outputs", {19'd0, busy, rsp1_valid, rsp0_valid, alu_op, alu_a, alu_b}, 32'd0);
    cyc;
    rst = 1'b0;

    // Single ADD 3+4 with latency check.
    set_req(1'b0, 1'b1, 3'd0, 4'd3, 4'd4);
    @(negedge clk);
    chk("single_ready", {31'd0, req0_ready}, 32'd1);
    cyc;
    set_req(1'b0, 1'b0, 3'd0, 4'd0, 4'd0);
    @(negedge clk);
    chk("single_issue", {20'd0, rsp0_valid, alu_op, alu_a, alu_b}, {20'd0, 1'b0, 3'd0, 4'd3, 4'd4});
    cyc;
    @(negedge clk);
    chk("single_rsp", {25'd0, rsp0_valid, rsp0_zero, rsp0_overflow, rsp0_result}, 32'h47);
    $display("single ADD 3+4 -> %0h", rsp0_result);

    // Backpressure: slot full and not taken blocks req0 and holds data.
    cyc;
    set_req(1'b0, 1'b1, 3'd1, 4'd2, 4'd5);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("bp_hold", {26'd0, req0_ready, rsp0_valid, rsp0_result}, {26'd0, 2'b01, 4'd7});
      cyc;
    end
    rsp0_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_grant", {31'd0, req0_ready}, 32'd1);
    cyc;
    rsp0_ready = 1'b0;
    set_req(1'b0, 1'b0, 3'd0, 4'd0, 4'd0);
    @(negedge clk);
    chk("bp_drained", {31'd0, rsp0_valid}, 32'd0);
    cyc;
    @(negedge clk);
    chk("bp_refill", {25'd0, rsp0_valid, rsp0_zero, rsp0_overflow, rsp0_result}, 32'h4D);
    $display("backpressure SUB 2-5 -> %0h", rsp0_result);
    cyc;
    rsp0_ready = 1'b1;

    // Overflow, compare and reserved opcodes.
    op_test("ovf_add", 1'b1, 3'd0, 4'b0111, 4'b0001, 6'b110000);
`ifdef ALU_ARB_OVF_STICKY_EN
    @(negedge clk);
    chk("sticky1_set", {30'd0, ovf_sticky1, ovf_sticky0}, 32'd2);
    cyc;
    ovf_clr = 1'b1;
    cyc;
    ovf_clr = 1'b0;
    @(negedge clk);
    chk("sticky1_clr", {31'd0, ovf_sticky1}, 32'd0);
    cyc;
`endif
    rsp1_ready = 1'b1;
    op_test("slt", 1'b0, 3'd6, 4'b1110, 4'b0001, 6'b000001);
    op_test("reserved", 1'b0, 3'd7, 4'd5, 4'd3, 6'b100000);
    op_test("xor", 1'b1, 3'd5, 4'b1100, 4'b1010, 6'b000110);
    op_test("not", 1'b0, 3'd2, 4'b1111, 4'd0, 6'b100000);

    // Contention from reset: grants alternate starting with PRIO.
    rst = 1'b1;
    cyc;
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      set_req(1'b0, 1'b1, 3'd0, 4'(k), 4'd1);
      set_req(1'b1, 1'b1, 3'd4, 4'(k), 4'd8);
      @(negedge clk);
      chk("contend_grant", {30'd0, req1_ready, req0_ready}, (k % 2 == 0) ? 32'd1 : 32'd2);
      if (k >= 2)
        chk("contend_rsp", {30'd0, rsp1_valid, rsp0_valid}, (k % 2 == 0) ? 32'd1 : 32'd2);
      $display("contend k=%0d ready=%b%b rsp=%b%b", k, req1_ready, req0_ready,
               rsp1_valid, rsp0_valid);
      cyc;
    end

    // Reset with issue stage and slot0 occupied.
    set_req(1'b0, 1'b0, 3'd0, 4'd0, 4'd0);
    set_req(1'b1, 1'b0, 3'd0, 4'd0, 4'd0);
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("pre_reset_busy", {30'd0, busy, rsp0_valid}, 32'd3);
    cyc;
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_zero", {13'd0, busy, rsp1_valid, rsp0_valid, alu_op, alu_a, alu_b,
                            rsp0_result, rsp0_overflow, rsp0_zero}, 32'd0);
    cyc;
    cyc;
    @(negedge clk);
    chk("no_stale_rsp", {29'd0, busy, rsp1_valid, rsp0_valid}, 32'd0);
    cyc;
    set_req(1'b0, 1'b1, 3'd3, 4'd6, 4'd3);
    set_req(1'b1, 1'b1, 3'd3, 4'd6, 4'd3);
    @(negedge clk);
    chk("tie_after_reset", {30'd0, req1_ready, req0_ready}, 32'd1);
    $display("tie after reset ready=%b%b", req1_ready, req0_ready);
    cyc;
    set_req(1'b0, 1'b0, 3'd0, 4'd0, 4'd0);
    set_req(1'b1, 1'b0, 3'd0, 4'd0, 4'd0);
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    repeat (4) cyc;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
